// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the pipeline hazard controller: operand forward selects and MDU FSM states.
package hazard_ctrl_unit_pkg;

  typedef enum logic [1:0] {
    FORWARD_NONE = 2'd0,
    FORWARD_WB   = 2'd1,
    FORWARD_MEM  = 2'd2
  } forward_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Data-memory wait handshake and MDU start/done handshake between the hazard unit and the datapath.
// Handshake: dmem_ready completes an M access in the same cycle mem_req_m is high; mdu_start is a one-cycle launch, mdu_done a one-cycle result pulse.
interface hazard_ctrl_unit_if;
  logic mem_req_m;
  logic dmem_ready;
  logic mdu_done;
  logic mdu_start;

  modport master (input mem_req_m, input dmem_ready, input mdu_done, output mdu_start);
  modport slave  (output mem_req_m, output dmem_ready, output mdu_done, input mdu_start);
endinterface

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// Per-operand E-stage forward select; the M-stage producer is younger so it beats W.
module fwd_sel
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_w,
  output forward_t          fwd
);

  always_comb begin
    fwd = FORWARD_NONE;
    if (rs != '0 && reg_write_m && rs == rd_m) fwd = FORWARD_MEM;
    else if (rs != '0 && reg_write_w && rs == rd_w) fwd = FORWARD_WB;
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// 5-stage pipeline hazard controller: stalls/flushes, forwarding, MDU start/done FSM, branch gating.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_ctrl_unit_if.master hz,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic              use_rs1_d,
  input  logic              use_rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              is_load_e,
  input  logic              mdu_op_e,
  input  logic              pc_src_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output forward_t          forward_a_e,
  output forward_t          forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic              redirect_en,
  output logic [CNT_W-1:0]  cnt_lu,
  output logic [CNT_W-1:0]  cnt_mem,
  output logic [CNT_W-1:0]  cnt_mdu,
  output logic [CNT_W-1:0]  cnt_br,
  output mdu_state_t        state_dbg
);

  mdu_state_t state;
  logic       done_q;
  logic       start_q;
  logic       mem_wait;
  logic       mdu_finish;
  logic       mdu_busy;
  logic       load_use;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs(rs1_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .fwd(forward_a_e)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs(rs2_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .fwd(forward_b_e)
  );

  assign mem_wait   = hz.mem_req_m & ~hz.dmem_ready;
  // A done latched during a memory wait counts as done once the wait clears.
  assign mdu_finish = (state == BUSY) & (hz.mdu_done | done_q);
  assign mdu_busy   = mdu_op_e & ~mdu_finish;
  assign load_use   = is_load_e & (rd_e != '0) &
                      ((use_rs1_d & (rs1_d == rd_e)) | (use_rs2_d & (rs2_d == rd_e)));

  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    flush_w     = 1'b0;
    redirect_en = 1'b0;
    if (!rst_n) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
      flush_w = 1'b1;
    end else if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (mdu_busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (pc_src_e) begin
      // E is not stalled here; a taken branch squashes D/E and overrides any load-use stall.
      redirect_en = 1'b1;
      flush_d     = 1'b1;
      flush_e     = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mdu_op_e && !mem_wait) begin
            state   <= BUSY;
            start_q <= 1'b1;
          end
        end
        BUSY: begin
          if (mem_wait) begin
            if (hz.mdu_done) done_q <= 1'b1;
          end else if (mdu_finish) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hz.mdu_start = start_q & rst_n;
  assign state_dbg    = state;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] lu_q, mem_q, mdu_q, br_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && !(&c)) ? c + CNT_W'(1) : c;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lu_q  <= '0;
      mem_q <= '0;
      mdu_q <= '0;
      br_q  <= '0;
    end else begin
      lu_q  <= sat_inc(lu_q, load_use & ~mem_wait & ~mdu_busy);
      mem_q <= sat_inc(mem_q, mem_wait);
      mdu_q <= sat_inc(mdu_q, (state == BUSY) & ~mem_wait);
      br_q  <= sat_inc(br_q, redirect_en);
    end
  end

  assign cnt_lu  = lu_q;
  assign cnt_mem = mem_q;
  assign cnt_mdu = mdu_q;
  assign cnt_br  = br_q;
`else
  assign cnt_lu  = '0;
  assign cnt_mem = '0;
  assign cnt_mdu = '0;
  assign cnt_br  = '0;
`endif

endmodule
